// File: rtl/hex_7seg_decoder.sv
// Registered hex-to-seven-segment decoder for one display digit.
// Segment a..g plus dot are registered so the display pins never glitch.
module hex_7seg_decoder #(
   parameter bit SEG_ACTIVE_LOW = 1'b0,
   parameter bit DOT_ON_ALPHA   = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] in,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       d,
   output logic       e,
   output logic       f,
   output logic       g,
   output logic       dot
);

   logic [6:0] w_seg_lit;
   logic       w_dot_lit;
   logic [6:0] r_seg;
   logic       r_dot;

   // Logical pattern, lit = 1, bit 6 is segment a.
   always_comb begin
      w_seg_lit = 7'b0000000;
      case (in)
         4'h0:    w_seg_lit = 7'b1111110;
         4'h1:    w_seg_lit = 7'b0110000;
         4'h2:    w_seg_lit = 7'b1101101;
         4'h3:    w_seg_lit = 7'b1111001;
         4'h4:    w_seg_lit = 7'b0110011;
         4'h5:    w_seg_lit = 7'b1011011;
         4'h6:    w_seg_lit = 7'b1011111;
         4'h7:    w_seg_lit = 7'b1110000;
         4'h8:    w_seg_lit = 7'b1111111;
         4'h9:    w_seg_lit = 7'b1111011;
         4'hA:    w_seg_lit = 7'b1110111;
         4'hB:    w_seg_lit = 7'b0011111;
         4'hC:    w_seg_lit = 7'b1001110;
         4'hD:    w_seg_lit = 7'b0111101;
         4'hE:    w_seg_lit = 7'b1001111;
         4'hF:    w_seg_lit = 7'b1000111;
         default: w_seg_lit = 7'b0000000;
      endcase
   end

   assign w_dot_lit = DOT_ON_ALPHA & (in >= 4'hA);

   // Polarity is folded in before the register so the pins come straight off flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seg <= {7{SEG_ACTIVE_LOW}};
         r_dot <= SEG_ACTIVE_LOW;
      end else begin
         r_seg <= w_seg_lit ^ {7{SEG_ACTIVE_LOW}};
         r_dot <= w_dot_lit ^ SEG_ACTIVE_LOW;
      end
   end

   assign {a, b, c, d, e, f, g} = r_seg;
   assign dot                   = r_dot;

endmodule

// File: tb/tb_hex_7seg_decoder.sv
// Bench for hex_7seg_decoder: three parameterisations share one stimulus stream
// and are compared against a lit-segment-letter reference model.
module tb_hex_7seg_decoder;

   logic       clk;
   logic       rst_n;
   logic [3:0] in;

   logic d_a, d_b, d_c, d_d, d_e, d_f, d_g, d_dot;
   logic l_a, l_b, l_c, l_d, l_e, l_f, l_g, l_dot;
   logic p_a, p_b, p_c, p_d, p_e, p_f, p_g, p_dot;

   int n_pass  = 0;
   int n_total = 0;

   hex_7seg_decoder #(.SEG_ACTIVE_LOW(1'b0), .DOT_ON_ALPHA(1'b0)) u_def (
      .clk(clk), .rst_n(rst_n), .in(in),
      .a(d_a), .b(d_b), .c(d_c), .d(d_d), .e(d_e), .f(d_f), .g(d_g), .dot(d_dot));

   hex_7seg_decoder #(.SEG_ACTIVE_LOW(1'b1), .DOT_ON_ALPHA(1'b0)) u_low (
      .clk(clk), .rst_n(rst_n), .in(in),
      .a(l_a), .b(l_b), .c(l_c), .d(l_d), .e(l_e), .f(l_f), .g(l_g), .dot(l_dot));

   hex_7seg_decoder #(.SEG_ACTIVE_LOW(1'b0), .DOT_ON_ALPHA(1'b1)) u_dot (
      .clk(clk), .rst_n(rst_n), .in(in),
      .a(p_a), .b(p_b), .c(p_c), .d(p_d), .e(p_e), .f(p_f), .g(p_g), .dot(p_dot));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   string lit_sets[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                           "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

   function automatic logic [6:0] seg_model(input logic [3:0] v);
      string      s;
      logic [6:0] r;
      int         idx;
      s = lit_sets[v];
      r = '0;
      for (int i = 0; i < s.len(); i++) begin
         idx = 6 - (int'(s[i]) - int'("a"));
         r[idx] = 1'b1;
      end
      return r;
   endfunction

   function automatic logic [7:0] pins_model(input logic unlit, input logic [3:0] v,
                                             input logic act_low, input logic dot_alpha);
      logic [7:0] lv;
      if (unlit) lv = 8'h00;
      else       lv = {seg_model(v), (dot_alpha && (v >= 4'd10))};
      return act_low ? ~lv : lv;
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   task automatic check_all(input string tag, input logic unlit, input logic [3:0] v);
      check($sformatf("%s def in=%h", tag, v),
            {d_a, d_b, d_c, d_d, d_e, d_f, d_g, d_dot}, pins_model(unlit, v, 1'b0, 1'b0));
      check($sformatf("%s low in=%h", tag, v),
            {l_a, l_b, l_c, l_d, l_e, l_f, l_g, l_dot}, pins_model(unlit, v, 1'b1, 1'b0));
      check($sformatf("%s dot in=%h", tag, v),
            {p_a, p_b, p_c, p_d, p_e, p_f, p_g, p_dot}, pins_model(unlit, v, 1'b0, 1'b1));
   endtask

   task automatic step(input logic [3:0] v);
      @(negedge clk);
      in = v;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] rv;
      rst_n = 1'b0;
      in    = 4'h0;

      // held in reset with clock running and input sweeping
      for (int v = 0; v < 16; v++) begin
         step(4'(v));
         check_all("in_reset", 1'b1, 4'(v));
      end

      @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < 16; v++) begin
         step(4'(v));
         check_all("sweep", 1'b0, 4'(v));
      end

      // mid-cycle input change must not reach the pins before the next edge
      step(4'h8);
      check_all("lat_pre", 1'b0, 4'h8);
      #2 in = 4'h1;
      #1 check_all("lat_hold", 1'b0, 4'h8);
      @(posedge clk);
      #1 check_all("lat_post", 1'b0, 4'h1);

      // asynchronous reset between edges
      step(4'h5);
      check_all("pre_rst", 1'b0, 4'h5);
      #2 rst_n = 1'b0;
      #1 check_all("async_rst", 1'b1, 4'h5);
      @(posedge clk);
      #1 check_all("rst_edge", 1'b1, 4'h5);
      @(negedge clk);
      in    = 4'h6;
      rst_n = 1'b1;
      @(posedge clk);
      #1 check_all("rst_release", 1'b0, 4'h6);

      // steady input stays steady
      for (int k = 0; k < 4; k++) begin
         step(4'h3);
         check_all("hold", 1'b0, 4'h3);
      end

      for (int k = 0; k < 40; k++) begin
         rv = 4'($urandom_range(0, 15));
         step(rv);
         check_all("rand", 1'b0, rv);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
